// File: rtl/codec2_lpc_pkg.sv
// Shared constants and state encoding for the Codec2 LPC analysis path.
package codec2_lpc_pkg;

    localparam int LPC_N     = 320;
    localparam int LPC_ORDER = 10;
    localparam int X_W       = 16;
    localparam int RN_W      = 32;
    localparam int RN_DEPTH  = 12;
    localparam int X_AW      = 9;
    localparam int RN_AW     = 4;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_INIT    = 4'd1,
        ST_CLR     = 4'd2,
        ST_SET_A   = 4'd3,
        ST_WAIT_A  = 4'd4,
        ST_GET_A   = 4'd5,
        ST_SET_B   = 4'd6,
        ST_WAIT_B  = 4'd7,
        ST_GET_B   = 4'd8,
        ST_MAC     = 4'd9,
        ST_CHECK_N = 4'd10,
        ST_WRITE   = 4'd11,
        ST_CHECK_K = 4'd12,
        ST_DONE    = 4'd13
    } ac_state_t;

endpackage

// File: rtl/autocorr_mac.sv
// Registered signed multiply-accumulate with synchronous clear and a
// shift-then-saturate-to-32-bit view of the accumulator.
module autocorr_mac
    import codec2_lpc_pkg::*;
#(
    parameter int ACC_W = 48,
    parameter int SHIFT = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    en,
    input  logic signed [X_W-1:0]   a,
    input  logic signed [X_W-1:0]   b,
    output logic signed [RN_W-1:0]  rn
);

    localparam logic signed [ACC_W-1:0] RN_MAX = {{(ACC_W-RN_W+1){1'b0}}, {(RN_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] RN_MIN = {{(ACC_W-RN_W+1){1'b1}}, {(RN_W-1){1'b0}}};

    logic signed [ACC_W-1:0]   acc;
    logic signed [2*X_W-1:0]   prod;
    logic signed [ACC_W-1:0]   shifted;

    assign prod    = a * b;
    assign shifted = acc >>> SHIFT;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + {{(ACC_W-2*X_W){prod[2*X_W-1]}}, prod};
        end
    end

    // Shift is arithmetic, so negative sums floor toward minus infinity.
    always_comb begin
        rn = shifted[RN_W-1:0];
        if (shifted > RN_MAX) begin
            rn = RN_MAX[RN_W-1:0];
        end else if (shifted < RN_MIN) begin
            rn = RN_MIN[RN_W-1:0];
        end
    end

endmodule

// File: rtl/autocorrelate_rn.sv
// LPC autocorrelation: computes R[0..ORDER] of one frame through a single-port
// sample RAM and writes each lag into the Rn RAM as it completes.
module autocorrelate_rn
    import codec2_lpc_pkg::*;
#(
    parameter int N     = LPC_N,
    parameter int ORDER = LPC_ORDER,
    parameter int SHIFT = 8,
    parameter int ACC_W = 48
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_ac,
    output logic [X_AW-1:0]   addr_x,
    input  logic [X_W-1:0]    q_x,
    output logic [RN_AW-1:0]  addr_rn,
    output logic [RN_W-1:0]   data_rn,
    output logic              wren_rn,
    output logic              busy_ac,
    output logic              done_ac,
    output logic [3:0]        state_dbg
);

    ac_state_t              state;
    logic [RN_AW-1:0]       k;
    logic [X_AW-1:0]        n;
    logic signed [X_W-1:0]  a;
    logic signed [X_W-1:0]  b;
    logic signed [RN_W-1:0] mac_rn;
    logic                   mac_clr;
    logic                   mac_en;

    assign state_dbg = state;
    assign mac_clr   = (state == ST_CLR);
    assign mac_en    = (state == ST_MAC);

    autocorr_mac #(
        .ACC_W (ACC_W),
        .SHIFT (SHIFT)
    ) u_mac (
        .clk (clk),
        .rst (rst),
        .clr (mac_clr),
        .en  (mac_en),
        .a   (a),
        .b   (b),
        .rn  (mac_rn)
    );

    // q_x reflects addr_x two states after it is set, hence the WAIT states.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            k       <= '0;
            n       <= '0;
            a       <= '0;
            b       <= '0;
            addr_x  <= '0;
            addr_rn <= '0;
            data_rn <= '0;
            wren_rn <= 1'b0;
            busy_ac <= 1'b0;
            done_ac <= 1'b0;
        end else begin
            wren_rn <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_ac) begin
                        state   <= ST_INIT;
                        done_ac <= 1'b0;
                        busy_ac <= 1'b1;
                    end
                end
                ST_INIT: begin
                    k     <= '0;
                    state <= ST_CLR;
                end
                ST_CLR: begin
                    n     <= X_AW'(k);
                    state <= ST_SET_A;
                end
                ST_SET_A: begin
                    addr_x <= n;
                    state  <= ST_WAIT_A;
                end
                ST_WAIT_A: state <= ST_GET_A;
                ST_GET_A: begin
                    a     <= q_x;
                    state <= ST_SET_B;
                end
                ST_SET_B: begin
                    addr_x <= n - X_AW'(k);
                    state  <= ST_WAIT_B;
                end
                ST_WAIT_B: state <= ST_GET_B;
                ST_GET_B: begin
                    b     <= q_x;
                    state <= ST_MAC;
                end
                ST_MAC: begin
                    n     <= n + 1'b1;
                    state <= ST_CHECK_N;
                end
                ST_CHECK_N: state <= (n < X_AW'(N)) ? ST_SET_A : ST_WRITE;
                ST_WRITE: begin
                    addr_rn <= k;
                    data_rn <= mac_rn;
                    wren_rn <= 1'b1;
                    state   <= ST_CHECK_K;
                end
                ST_CHECK_K: begin
                    k     <= k + 1'b1;
                    state <= (k < RN_AW'(ORDER)) ? ST_CLR : ST_DONE;
                end
                ST_DONE: begin
                    done_ac <= 1'b1;
                    busy_ac <= 1'b0;
                    state   <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_autocorrelate_rn.sv
// Randomised and directed frames on three instances (full length, short frame,
// short frame with no shift) compared against a plain-arithmetic lag model.
`timescale 1ns/1ps
module tb_autocorrelate_rn;

    localparam int NI      = 3;
    localparam int FULL_N  = 320;
    localparam int SMALL_N = 24;
    localparam int ORDER   = 10;
    localparam longint SAT_MAX = 64'sd2147483647;
    localparam longint SAT_MIN = -64'sd2147483648;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst       [NI];
    logic        start_ac  [NI];
    logic [8:0]  addr_x    [NI];
    logic [3:0]  addr_rn   [NI];
    logic [31:0] data_rn   [NI];
    logic        wren_rn   [NI];
    logic        busy_ac   [NI];
    logic        done_ac   [NI];
    logic [3:0]  state_dbg [NI];
    logic signed [15:0] mem [NI][0:FULL_N-1];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    generate
        for (genvar g = 0; g < NI; g++) begin : g_dut
            logic [15:0] q;
            always @(posedge clk) q <= mem[g][addr_x[g]];
            autocorrelate_rn #(
                .N     ((g == 0) ? FULL_N : SMALL_N),
                .ORDER (ORDER),
                .SHIFT ((g == 2) ? 0 : 8),
                .ACC_W (48)
            ) dut (
                .clk       (clk),
                .rst       (rst[g]),
                .start_ac  (start_ac[g]),
                .addr_x    (addr_x[g]),
                .q_x       (q),
                .addr_rn   (addr_rn[g]),
                .data_rn   (data_rn[g]),
                .wren_rn   (wren_rn[g]),
                .busy_ac   (busy_ac[g]),
                .done_ac   (done_ac[g]),
                .state_dbg (state_dbg[g])
            );
        end
    endgenerate

    // Rn RAM write monitor (only one instance is active at a time).
    logic [3:0]  got_addr_q[$];
    logic [31:0] got_data_q[$];
    int          got_cyc_q[$];
    always @(negedge clk) begin
        for (int g = 0; g < NI; g++) begin
            if (wren_rn[g] === 1'b1) begin
                got_addr_q.push_back(addr_rn[g]);
                got_data_q.push_back(data_rn[g]);
                got_cyc_q.push_back(cyc);
            end
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int inst_n(input int i);
        return (i == 0) ? FULL_N : SMALL_N;
    endfunction

    function automatic int inst_shift(input int i);
        return (i == 2) ? 0 : 8;
    endfunction

    // R[k] = sat32(floor(sum x[n]*x[n-k] / 2^shift))
    function automatic logic [31:0] ref_lag(input int i, input int k);
        longint acc;
        longint sh;
        acc = 0;
        for (int n = k; n < inst_n(i); n++)
            acc += longint'(mem[i][n]) * longint'(mem[i][n-k]);
        sh = acc >>> inst_shift(i);
        if (sh > SAT_MAX) sh = SAT_MAX;
        if (sh < SAT_MIN) sh = SAT_MIN;
        return sh[31:0];
    endfunction

    function automatic logic [31:0] got_at(input int k);
        return (got_data_q.size() > k) ? got_data_q[k] : 32'hxxxxxxxx;
    endfunction

    task automatic fill(input int i, input int mode);
        for (int n = 0; n < FULL_N; n++) begin
            case (mode)
                0:       mem[i][n] = 16'sd0;
                1:       mem[i][n] = (n == 0) ? 16'sd1000 : 16'sd0;
                2:       mem[i][n] = 16'sd256;
                3:       mem[i][n] = (n % 2 == 0) ? 16'sd100 : -16'sd100;
                4:       mem[i][n] = 16'h8000;
                5:       mem[i][n] = (n % 2 == 0) ? 16'h8000 : 16'h7fff;
                default: mem[i][n] = 16'($urandom_range(0, 65535));
            endcase
        end
    endtask

    task automatic clear_got();
        got_addr_q.delete();
        got_data_q.delete();
        got_cyc_q.delete();
    endtask

    task automatic check_reset_outputs(input int i);
        check_eq("rst_addr_x", 64'(addr_x[i]), 0);
        check_eq("rst_addr_rn", 64'(addr_rn[i]), 0);
        check_eq("rst_data_rn", 64'(data_rn[i]), 0);
        check_eq("rst_wren_rn", 64'(wren_rn[i]), 0);
        check_eq("rst_busy_ac", 64'(busy_ac[i]), 0);
        check_eq("rst_done_ac", 64'(done_ac[i]), 0);
        check_eq("rst_state", 64'(state_dbg[i]), 0);
    endtask

    // Runs one frame; edges counts the start-sampling edge as edge 1.
    task automatic run_frame(input int i, input bit pulse_lag2);
        logic [31:0] exp_q[$];
        int edges;
        int lag_sum;
        bit pulsed;
        lag_sum = 0;
        for (int k = 0; k <= ORDER; k++) begin
            lag_sum += 3 + 8 * (inst_n(i) - k);
            exp_q.push_back(ref_lag(i, k));
        end
        clear_got();
        @(negedge clk);
        start_ac[i] = 1'b1;
        @(posedge clk);
        #1;
        start_ac[i] = 1'b0;
        edges  = 1;
        pulsed = 1'b0;
        check_eq("busy_on_start", 64'(busy_ac[i]), 1);
        check_eq("done_cleared_on_start", 64'(done_ac[i]), 0);
        while (done_ac[i] !== 1'b1 && edges < lag_sum + 100) begin
            if (pulse_lag2 && !pulsed && got_addr_q.size() == 2) begin
                start_ac[i] = 1'b1;
                pulsed = 1'b1;
            end else begin
                start_ac[i] = 1'b0;
            end
            @(posedge clk);
            #1;
            edges++;
        end
        start_ac[i] = 1'b0;
        check_eq("done_edge", 64'(edges), 64'(lag_sum + 3));
        check_eq("busy_at_done", 64'(busy_ac[i]), 0);
        repeat (10) @(posedge clk);
        #1;
        check_eq("busy_after_done", 64'(busy_ac[i]), 0);
        check_eq("done_held", 64'(done_ac[i]), 1);
        check_eq("write_count", 64'(got_addr_q.size()), 11);
        for (int k = 0; k <= ORDER && k < got_addr_q.size(); k++) begin
            check_eq("rn_addr", 64'(got_addr_q[k]), 64'(k));
            check_eq("rn_data", 64'(got_data_q[k]), 64'(exp_q[k]));
            if (k > 0)
                check_eq("write_gap", 64'(got_cyc_q[k] - got_cyc_q[k-1]),
                         64'(3 + 8 * (inst_n(i) - k)));
        end
        check_eq("addr_rn_held", 64'(addr_rn[i]), 64'(ORDER));
        check_eq("data_rn_held", 64'(data_rn[i]), 64'(exp_q[ORDER]));
    endtask

    initial begin
        for (int i = 0; i < NI; i++) begin
            rst[i]      = 1'b0;
            start_ac[i] = 1'b0;
            fill(i, 0);
        end
        #1;
        for (int i = 0; i < NI; i++) check_reset_outputs(i);
        repeat (2) @(negedge clk);
        for (int i = 0; i < NI; i++) rst[i] = 1'b1;
        repeat (2) @(negedge clk);

        // Full-length frame with the spec's constant input.
        fill(0, 2);
        run_frame(0, 1'b0);
        check_eq("const_r0", 64'(got_at(0)), 64'(81920));
        check_eq("const_r10", 64'(got_at(10)), 64'(79360));

        // Short frames.
        fill(1, 0);
        run_frame(1, 1'b0);
        check_eq("zero_r0", 64'(got_at(0)), 0);
        fill(1, 1);
        run_frame(1, 1'b0);
        check_eq("impulse_r0", 64'(got_at(0)), 64'(3906));
        check_eq("impulse_r1", 64'(got_at(1)), 0);
        fill(1, 3);
        run_frame(1, 1'b0);
        check_eq("alt_r0", 64'(got_at(0)), 64'(937));
        check_eq("alt_r1", 64'(got_at(1)), 64'(32'hfffffc7d));
        check_eq("alt_r2", 64'(got_at(2)), 64'(859));
        for (int r = 0; r < 2; r++) begin
            fill(1, 6);
            run_frame(1, 1'b0);
        end

        // Reset during lag 4, then a restart with a dropped start request.
        fill(1, 6);
        clear_got();
        @(negedge clk);
        start_ac[1] = 1'b1;
        @(posedge clk);
        #1;
        start_ac[1] = 1'b0;
        for (int c = 0; c < 3000 && got_addr_q.size() < 4; c++) begin
            @(posedge clk);
            #1;
        end
        check_eq("reach_lag4", 64'(got_addr_q.size()), 4);
        repeat (17) @(posedge clk);
        #1;
        rst[1] = 1'b0;
        #1;
        check_reset_outputs(1);
        repeat (3) @(negedge clk);
        rst[1] = 1'b1;
        repeat (300) @(posedge clk);
        #1;
        check_eq("no_write_after_reset", 64'(got_addr_q.size()), 4);
        check_eq("idle_after_reset_busy", 64'(busy_ac[1]), 0);
        check_eq("idle_after_reset_done", 64'(done_ac[1]), 0);
        run_frame(1, 1'b1);

        // Saturation with no shift.
        fill(2, 4);
        run_frame(2, 1'b0);
        check_eq("sat_pos_r0", 64'(got_at(0)), 64'(32'h7fffffff));
        fill(2, 5);
        run_frame(2, 1'b0);
        check_eq("sat_neg_r1", 64'(got_at(1)), 64'(32'h80000000));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
